// File: rtl/chk_pkg.sv
// chk_pkg: shared FSM states, lane encoding and expectation entry layout for the sequence checker.
package chk_pkg;
  localparam int WIDTH_D = 8;
  localparam int CYC_W_D = 16;
  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;
  localparam logic [1:0] LANE_D = 2'd3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [CYC_W_D-1:0] cycle;
    logic [1:0]         lane;
    logic [WIDTH_D-1:0] value;
  } exp_entry_t;
endpackage

// File: rtl/expect_table.sv
// expect_table: expectation register file, one synchronous write port and one asynchronous read port.
module expect_table
  import chk_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  exp_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output exp_entry_t    rdata
);
  exp_entry_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/expect_seq_checker.sv
// expect_seq_checker: compares four observed lanes against a programmed (cycle, lane, value) schedule.
// Entry field widths come from chk_pkg, so WIDTH and CYC_W must match WIDTH_D and CYC_W_D.
module expect_seq_checker
  import chk_pkg::*;
#(
  parameter int WIDTH   = WIDTH_D,
  parameter int DEPTH   = 16,
  parameter int CYC_W   = CYC_W_D,
  parameter int TIMEOUT = 100,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             exp_we,
  input  logic [AW-1:0]    exp_addr,
  input  logic [CYC_W-1:0] exp_cycle,
  input  logic [1:0]       exp_lane,
  input  logic [WIDTH-1:0] exp_value,
  input  logic [AW:0]      exp_count,
  input  logic [WIDTH-1:0] lane_a,
  input  logic [WIDTH-1:0] lane_b,
  input  logic [WIDTH-1:0] lane_c,
  input  logic [WIDTH-1:0] lane_d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_cnt,
  output logic [AW-1:0]    first_fail
);
  state_t state, state_n;
  exp_entry_t ent, wr_ent;
  logic [CYC_W-1:0] cyc;
  logic [AW:0] ptr, cnt, tmo_err;
  logic [AW-1:0] pend_idx, ff_n;
  logic [WIDTH-1:0] lane_v;
  logic [15:0] sum;
  logic [7:0] err_n;
  logic run, arm, tmo, left, fin, hit, bad, pend_v, pend_bad;
  assign wr_ent = '{cycle: CYC_W_D'(exp_cycle), lane: exp_lane, value: WIDTH_D'(exp_value)};
  expect_table #(.DEPTH(DEPTH)) u_table (
    .clk   (clk),
    .we    (exp_we && state != RUN),
    .waddr (exp_addr),
    .wdata (wr_ent),
    .raddr (ptr[AW-1:0]),
    .rdata (ent)
  );
  assign run  = state == RUN;
  assign busy = run;
  assign done = state == DONE;
  assign pass = done && err_cnt == '0;
  assign arm  = start && !run;
  // An entry at or behind the counter is consumed: equal cycle compares, earlier cycle is a missed slot.
  always_comb begin
    lane_v  = ent.lane == LANE_A ? lane_a : ent.lane == LANE_B ? lane_b : ent.lane == LANE_C ? lane_c : lane_d;
    tmo     = run && cyc == CYC_W'(TIMEOUT);
    left    = ptr < cnt;
    fin     = run && !left;
    hit     = run && !tmo && left && CYC_W'(ent.cycle) <= cyc;
    bad     = CYC_W'(ent.cycle) != cyc || lane_v != WIDTH'(ent.value);
    tmo_err = (tmo && left) ? cnt - ptr : '0;
    sum     = 16'(err_cnt) + 16'(pend_v & pend_bad) + 16'(tmo_err);
    err_n   = sum > 16'd255 ? 8'hff : sum[7:0];
    ff_n    = err_cnt != '0 ? first_fail : (pend_v && pend_bad) ? pend_idx : tmo_err != '0 ? ptr[AW-1:0] : first_fail;
    state_n = state;
    if (run) state_n = (tmo || fin) ? DONE : RUN;
    else if (start) state_n = exp_count == '0 ? DONE : RUN;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      cyc        <= '0;
      ptr        <= '0;
      cnt        <= '0;
      pend_v     <= 1'b0;
      pend_bad   <= 1'b0;
      pend_idx   <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      state    <= state_n;
      pend_v   <= hit;
      pend_bad <= bad;
      pend_idx <= ptr[AW-1:0];
      if (arm) begin
        cyc        <= '0;
        ptr        <= '0;
        cnt        <= exp_count;
        err_cnt    <= '0;
        first_fail <= '0;
      end else begin
        if (run && state_n == RUN) cyc <= cyc + 1'b1;
        if (hit) ptr <= ptr + 1'b1;
        err_cnt    <= err_n;
        first_fail <= ff_n;
      end
    end
endmodule
